uart_cmd_parser: RTL

Byte-stream command parser sitting directly downstream of the UART receiver and upstream of the UART transmitter. It assembles received bytes into two-byte command packets (command, address), validates them, and issues a one-cycle command strobe to the application. It then hands a 16-bit reply word (acknowledge or error) to the transmitter through a request/busy handshake. An inter-byte timeout discards half-received packets.

---
 rtl/uart_cmd_parser.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - two-byte UART command parser with reply handshake
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   rx_data    in   8   received byte, valid with rx_valid
//   rx_valid   in   1   one-cycle receive strobe
//   cmd        out  8   command code of the last valid packet
//   addr       out  8   address of the last valid packet
//   cmd_valid  out  1   one-cycle strobe when cmd/addr are updated
//   tx_word    out  16  reply word for the transmitter
//   tx_start   out  1   transmit request, held until tx_busy is seen high
//   tx_busy    in   1   transmitter busy
//   overrun    out  1   sticky: byte received while a reply was pending
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [7:0]  MAX_CMD        = 8'h07,
  parameter logic [7:0]  MAX_ADDR       = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  cmd,
  output logic [7:0]  addr,
  output logic        cmd_valid,
  output logic [15:0] tx_word,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        overrun
);

  localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] ERR_CMD     = 8'hE1;
  localparam logic [7:0] ERR_ADDR    = 8'hE2;
  localparam logic [7:0] ERR_TIMEOUT = 8'hE3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ADDR,
    CHECK,
    SEND,
    WAIT_TX
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          expired, expired_nxt;
  logic [7:0]    first_byte, first_nxt;
  logic [7:0]    second_byte, second_nxt;
  logic [7:0]    cmd_nxt, addr_nxt;
  logic          cmd_valid_nxt;
  logic [15:0]   tx_word_nxt;
  logic          tx_start_nxt;
  logic          overrun_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      expired     <= 1'b0;
      first_byte  <= 8'h00;
      second_byte <= 8'h00;
      cmd         <= 8'h00;
      addr        <= 8'h00;
      cmd_valid   <= 1'b0;
      tx_word     <= 16'h0000;
      tx_start    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      expired     <= expired_nxt;
      first_byte  <= first_nxt;
      second_byte <= second_nxt;
      cmd         <= cmd_nxt;
      addr        <= addr_nxt;
      cmd_valid   <= cmd_valid_nxt;
      tx_word     <= tx_word_nxt;
      tx_start    <= tx_start_nxt;
      overrun     <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    expired_nxt   = 1'b0;
    first_nxt     = first_byte;
    second_nxt    = second_byte;
    cmd_nxt       = cmd;
    addr_nxt      = addr;
    cmd_valid_nxt = 1'b0;
    tx_word_nxt   = tx_word;
    overrun_nxt   = overrun;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          first_nxt = rx_data;
          cnt_nxt   = '0;
          state_nxt = WAIT_ADDR;
        end
      end

      WAIT_ADDR: begin
        // A byte arriving on the expiry cycle still completes the packet.
        if (rx_valid) begin
          second_nxt = rx_data;
          state_nxt  = CHECK;
        end else if (expired) begin
          tx_word_nxt = {ERR_TIMEOUT, first_byte};
          state_nxt   = SEND;
        end else begin
          // The counter parks at its last value; the expiry flag is registered
          // from it so the request rises TIMEOUT_CYCLES+1 edges after the
          // first byte.
          if (cnt != CNT_LAST) begin
            cnt_nxt = cnt + CW'(1);
          end
          expired_nxt = (cnt == CNT_LAST);
        end
      end

      CHECK: begin
        if (first_byte == 8'h00 || first_byte > MAX_CMD) begin
          tx_word_nxt = {ERR_CMD, first_byte};
        end else if (second_byte == 8'h00 || second_byte > MAX_ADDR) begin
          tx_word_nxt = {ERR_ADDR, first_byte};
        end else begin
          cmd_nxt       = first_byte;
          addr_nxt      = second_byte;
          cmd_valid_nxt = 1'b1;
          tx_word_nxt   = {first_byte, second_byte};
        end
        state_nxt = SEND;
        if (rx_valid) begin
          overrun_nxt = 1'b1;
        end
      end

      SEND: begin
        if (tx_busy) begin
          state_nxt = WAIT_TX;
        end
        if (rx_valid) begin
          overrun_nxt = 1'b1;
        end
      end

      WAIT_TX: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
        if (rx_valid) begin
          overrun_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Request is a registered copy of "next state is SEND".
    tx_start_nxt = (state_nxt == SEND);
  end

endmodule
